// File: rtl/trigger_debouncer.sv
// trigger_debouncer: synchronises a raw, possibly bouncing input and commits a
// level change only after it has held the new value for DEBOUNCE_CYCLES
// consecutive samples. It also provides rise/fall strobes, a busy flag and a
// saturating count of rejected glitches.
module trigger_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  output logic       trigger,
  output logic       rise,
  output logic       fall,
  output logic       busy,
  output logic [7:0] glitch_cnt
);

  typedef enum logic [1:0] {
    S_LOW      = 2'd0,
    S_CHK_HIGH = 2'd1,
    S_HIGH     = 2'd2,
    S_CHK_LOW  = 2'd3
  } state_t;

  // Value of cnt on the sample that completes a qualification.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_q;
  state_t                 state, state_n;
  logic [CNT_W-1:0]       cnt, cnt_n;
  logic                   rise_n, fall_n, glitch_inc;

  // Glitch counter increment that sticks at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign sync_q = sync[SYNC_STAGES-1];

  // Plain shift-chain synchroniser; only sync[0] may go metastable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync <= '0;
    else      sync <= {sync[SYNC_STAGES-2:0], btn_in};
  end

  // FSM state and stability counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_LOW;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state logic; an abort is checked before completion so it wins a tie.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    rise_n     = 1'b0;
    fall_n     = 1'b0;
    glitch_inc = 1'b0;
    unique case (state)
      S_LOW: begin
        if (sync_q) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_n = S_HIGH;
            rise_n  = 1'b1;
          end else begin
            state_n = S_CHK_HIGH;
            cnt_n   = CNT_W'(1);
          end
        end
      end
      S_CHK_HIGH: begin
        if (!sync_q) begin
          state_n    = S_LOW;
          cnt_n      = '0;
          glitch_inc = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_n = S_HIGH;
          cnt_n   = '0;
          rise_n  = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_HIGH: begin
        if (!sync_q) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_n = S_LOW;
            fall_n  = 1'b1;
          end else begin
            state_n = S_CHK_LOW;
            cnt_n   = CNT_W'(1);
          end
        end
      end
      S_CHK_LOW: begin
        if (sync_q) begin
          state_n    = S_HIGH;
          cnt_n      = '0;
          glitch_inc = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_n = S_LOW;
          cnt_n   = '0;
          fall_n  = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = S_LOW;
        cnt_n   = '0;
      end
    endcase
  end

  // Registered outputs derived from the state being entered on this edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trigger    <= 1'b0;
      rise       <= 1'b0;
      fall       <= 1'b0;
      busy       <= 1'b0;
      glitch_cnt <= 8'd0;
    end else begin
      trigger <= (state_n == S_HIGH) || (state_n == S_CHK_LOW);
      busy    <= (state_n == S_CHK_HIGH) || (state_n == S_CHK_LOW);
      rise    <= rise_n;
      fall    <= fall_n;
      if (glitch_inc) glitch_cnt <= sat_inc(glitch_cnt);
    end
  end

endmodule

// File: tb/tb_trigger_debouncer.sv
// Directed testbench for trigger_debouncer with default parameters
// (SYNC_STAGES=2, DEBOUNCE_CYCLES=4: commit six edges after first sample).
module tb_trigger_debouncer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_in = 1'b0;
  logic       trigger, rise, fall, busy;
  logic [7:0] glitch_cnt;

  int errors = 0;
  int checks = 0;

  trigger_debouncer dut (
    .clk        (clk),
    .rst        (rst),
    .btn_in     (btn_in),
    .trigger    (trigger),
    .rise       (rise),
    .fall       (fall),
    .busy       (busy),
    .glitch_cnt (glitch_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive btn_in, then advance past the next rising edge.
  task automatic step(input logic b);
    btn_in = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int trig_seen;
    int strobe_seen;

    // Reset held with btn_in high: everything stays zero.
    rst = 1'b0;
    btn_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk("rst_trigger", trigger, 0);
      chk("rst_rise", rise, 0);
      chk("rst_busy", busy, 0);
      chk("rst_glitch", glitch_cnt, 0);
    end
    rst = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step(1'b1);
      chk("rel_rise", rise, (k == 6));
      chk("rel_trigger", trigger, (k >= 6));
      chk("rel_busy", busy, (k >= 3 && k <= 5));
    end

    // Fall latency matches rise latency.
    for (int k = 1; k <= 8; k++) begin
      step(1'b0);
      chk("fall_strobe", fall, (k == 6));
      chk("fall_trigger", trigger, (k < 6));
    end

    // Clean press of 10 cycles then release.
    for (int k = 1; k <= 20; k++) begin
      step(k <= 10);
      chk("clean_trigger", trigger, (k >= 6 && k < 16));
      chk("clean_rise", rise, (k == 6));
      chk("clean_fall", fall, (k == 16));
      chk("clean_busy", busy, ((k >= 3 && k <= 5) || (k >= 13 && k <= 15)));
    end
    chk("clean_glitch", glitch_cnt, 0);

    // Three-cycle high is rejected.
    for (int k = 1; k <= 8; k++) begin
      step(k <= 3);
      chk("short_trigger", trigger, 0);
      chk("short_rise", rise, 0);
      chk("short_busy", busy, (k >= 3 && k <= 5));
    end
    chk("short_glitch", glitch_cnt, 1);

    // Four-cycle high commits, then releases.
    for (int k = 1; k <= 12; k++) begin
      step(k <= 4);
      chk("min_rise", rise, (k == 6));
      chk("min_fall", fall, (k == 10));
      chk("min_trigger", trigger, (k >= 6 && k < 10));
    end
    chk("min_glitch", glitch_cnt, 1);

    // Bounce train 1,0,1,1,0,1 then held high: two aborts, one rise.
    begin
      logic [5:0] pat;
      pat = 6'b101101;
      for (int k = 1; k <= 14; k++) begin
        step((k <= 6) ? pat[6-k] : 1'b1);
        chk("bounce_rise", rise, (k == 11));
        chk("bounce_trigger", trigger, (k >= 11));
      end
    end
    chk("bounce_glitch", glitch_cnt, 3);
    for (int k = 1; k <= 8; k++) step(1'b0);
    chk("bounce_low", trigger, 0);

    // Reset dropped mid-qualification clears at once.
    for (int k = 1; k <= 4; k++) step(1'b1);
    chk("mid_busy_before", busy, 1);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_cnt", dut.cnt, 0);
    chk("mid_trigger", trigger, 0);
    chk("mid_rise", rise, 0);
    chk("mid_glitch", glitch_cnt, 0);
    @(posedge clk);
    #1;
    chk("mid_hold_busy", busy, 0);
    rst = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step(1'b1);
      chk("mid_rel_rise", rise, (k == 6));
      chk("mid_rel_trigger", trigger, (k >= 6));
    end
    for (int k = 1; k <= 8; k++) step(1'b0);
    chk("mid_low", trigger, 0);

    // 300 three-cycle glitches: counter saturates at 255.
    trig_seen = 0;
    strobe_seen = 0;
    for (int g = 1; g <= 300; g++) begin
      for (int k = 1; k <= 6; k++) begin
        step(k <= 3);
        if (trigger) trig_seen++;
        if (rise || fall) strobe_seen++;
      end
      chk("sat_count", glitch_cnt, (g < 255) ? g : 255);
    end
    chk("sat_trigger_seen", trig_seen, 0);
    chk("sat_strobe_seen", strobe_seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
